// File: rtl/noc_dev_ctrl.sv
// noc_dev_ctrl: device-side endpoint of the byte-serial NoC link.
// Parses the CmdW/DataW command stream, issues register writes, and queues
// read and write-ack requests in a small FIFO. A responder drains the FIFO
// and produces the CmdR/DataR response stream.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   CmdW, DataW     inbound stream (CmdW=1 marks a header byte)
//   CmdR, DataR     outbound stream (CmdR=1 marks a header/idle byte)
//   reg_we, reg_waddr, reg_wdata   one-cycle register write strobe
//   reg_raddr, reg_rdata           register read port (rdata combinational)
//   err_clr         clears sticky error flags
//   err_ovf         sticky: request dropped because the FIFO was full
//   err_proto       sticky: illegal opcode or aborted packet
module noc_dev_ctrl #(
  parameter int unsigned RQ_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       CmdW,
  input  logic [7:0] DataW,
  output logic       CmdR,
  output logic [7:0] DataR,
  output logic       reg_we,
  output logic [7:0] reg_waddr,
  output logic [7:0] reg_wdata,
  output logic [7:0] reg_raddr,
  input  logic [7:0] reg_rdata,
  input  logic       err_clr,
  output logic       err_ovf,
  output logic       err_proto
);

  localparam int unsigned AW = $clog2(RQ_DEPTH);

  typedef enum logic [1:0] {P_IDLE, P_ADDR, P_LEN, P_DATA} pState_t;
  typedef enum logic [1:0] {R_IDLE, R_HDR, R_DATA} rState_t;

  // ---------------- parser ----------------
  pState_t    pState, pStateNext;
  logic       pIsWr, pIsWrNext;
  logic [7:0] pAddr, pAddrNext;
  logic [7:0] pLen, pLenNext;
  logic [7:0] pIdx, pIdxNext;
  logic       push;
  logic [7:0] pushLen;
  logic       weNext;
  logic [7:0] waddrNext, wdataNext;
  logic       protoSet;

  always_comb begin
    pStateNext = pState;
    pIsWrNext  = pIsWr;
    pAddrNext  = pAddr;
    pLenNext   = pLen;
    pIdxNext   = pIdx;
    push       = 1'b0;
    pushLen    = pLen;
    weNext     = 1'b0;
    waddrNext  = reg_waddr;
    wdataNext  = reg_wdata;
    protoSet   = 1'b0;
    if (CmdW) begin
      // A header mid-packet aborts it and is then decoded as a fresh header.
      if (pState != P_IDLE) protoSet = 1'b1;
      pStateNext = P_IDLE;
      case (DataW[7:5])
        3'b000: ;
        3'b001: begin pStateNext = P_ADDR; pIsWrNext = 1'b0; end
        3'b010: begin pStateNext = P_ADDR; pIsWrNext = 1'b1; end
        default: protoSet = 1'b1;
      endcase
    end else begin
      case (pState)
        P_ADDR: begin
          pAddrNext  = DataW;
          pStateNext = P_LEN;
        end
        P_LEN: begin
          pLenNext = DataW;
          pIdxNext = '0;
          pushLen  = DataW;
          if (!pIsWr || DataW == 8'd0) begin
            push       = 1'b1;
            pStateNext = P_IDLE;
          end else begin
            pStateNext = P_DATA;
          end
        end
        P_DATA: begin
          weNext    = 1'b1;
          waddrNext = pAddr + pIdx;
          wdataNext = DataW;
          pIdxNext  = pIdx + 8'd1;
          if (pIdx == pLen - 8'd1) begin
            push       = 1'b1;
            pStateNext = P_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pState    <= P_IDLE;
      pIsWr     <= 1'b0;
      pAddr     <= '0;
      pLen      <= '0;
      pIdx      <= '0;
      reg_we    <= 1'b0;
      reg_waddr <= '0;
      reg_wdata <= '0;
    end else begin
      pState    <= pStateNext;
      pIsWr     <= pIsWrNext;
      pAddr     <= pAddrNext;
      pLen      <= pLenNext;
      pIdx      <= pIdxNext;
      reg_we    <= weNext;
      reg_waddr <= waddrNext;
      reg_wdata <= wdataNext;
    end
  end

  // ---------------- request FIFO ----------------
  // Entry: {isWr, addr, len}
  logic [16:0] fifo [RQ_DEPTH];
  logic [AW:0] wrPtr, rdPtr;
  logic        empty, full, pop, doPush, ovfSet;
  rState_t     rState, rStateNext;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign pop    = (rState == R_IDLE) && !empty;
  assign doPush = push && (!full || pop);
  assign ovfSet = push && full && !pop;

  always_ff @(posedge clk) begin
    if (doPush) fifo[wrPtr[AW-1:0]] <= {pIsWr, pAddr, pushLen};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (pop)    rdPtr <= rdPtr + 1'b1;
    end
  end

  // ---------------- responder ----------------
  logic       rIsWr;
  logic [7:0] rAddr;
  logic [7:0] rLen, rLenNext;
  logic       cmdRNext;
  logic [7:0] dataRNext, raddrNext;

  always_comb begin
    rStateNext = rState;
    rLenNext   = rLen;
    cmdRNext   = 1'b1;
    dataRNext  = 8'h00;
    raddrNext  = reg_raddr;
    case (rState)
      R_IDLE: if (!empty) rStateNext = R_HDR;
      R_HDR: begin
        dataRNext = rIsWr ? 8'hC0 : 8'hA0;
        raddrNext = rAddr;
        rStateNext = (!rIsWr && rLen != 8'd0) ? R_DATA : R_IDLE;
      end
      R_DATA: begin
        // rLen counts data bytes still to emit.
        cmdRNext  = 1'b0;
        dataRNext = reg_rdata;
        raddrNext = reg_raddr + 8'd1;
        rLenNext  = rLen - 8'd1;
        if (rLen == 8'd1) rStateNext = R_IDLE;
      end
      default: rStateNext = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rState    <= R_IDLE;
      rIsWr     <= 1'b0;
      rAddr     <= '0;
      rLen      <= '0;
      CmdR      <= 1'b1;
      DataR     <= 8'h00;
      reg_raddr <= '0;
    end else begin
      rState    <= rStateNext;
      CmdR      <= cmdRNext;
      DataR     <= dataRNext;
      reg_raddr <= raddrNext;
      if (pop) {rIsWr, rAddr, rLen} <= fifo[rdPtr[AW-1:0]];
      else     rLen <= rLenNext;
    end
  end

  // ---------------- sticky errors (set wins over clear) ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_ovf   <= 1'b0;
      err_proto <= 1'b0;
    end else begin
      if (ovfSet)       err_ovf <= 1'b1;
      else if (err_clr) err_ovf <= 1'b0;
      if (protoSet)     err_proto <= 1'b1;
      else if (err_clr) err_proto <= 1'b0;
    end
  end

endmodule

// File: tb/tb_noc_dev_ctrl.sv
module tb_noc_dev_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       CmdW;
  logic [7:0] DataW;
  logic       CmdR;
  logic [7:0] DataR;
  logic       reg_we;
  logic [7:0] reg_waddr, reg_wdata, reg_raddr, reg_rdata;
  logic       err_clr;
  logic       err_ovf, err_proto;

  int nChecks = 0;
  int nPassed = 0;
  int hdrA0, ackC0, weCnt, bad;

  // Register file model: 0x10 and 0x11 are writable, others read addr^5A.
  logic [7:0] r10, r11;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      r10 <= 8'h4A;
      r11 <= 8'h4B;
    end else if (reg_we) begin
      if (reg_waddr == 8'h10) r10 <= reg_wdata;
      if (reg_waddr == 8'h11) r11 <= reg_wdata;
    end
  end
  assign reg_rdata = (reg_raddr == 8'h10) ? r10 :
                     (reg_raddr == 8'h11) ? r11 : (reg_raddr ^ 8'h5A);

  always #5 clk = ~clk;

  noc_dev_ctrl #(.RQ_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .CmdW(CmdW), .DataW(DataW),
    .CmdR(CmdR), .DataR(DataR),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .err_clr(err_clr), .err_ovf(err_ovf), .err_proto(err_proto)
  );

  // Drive one byte, let it be captured, then observe #1 after the edge.
  task automatic step(input logic c, input logic [7:0] d);
    CmdW  = c;
    DataW = d;
    @(posedge clk);
    #1;
    if (CmdR && DataR == 8'hA0) hdrA0++;
    if (CmdR && DataR == 8'hC0) ackC0++;
    if (reg_we) weCnt++;
    if (!CmdR || DataR != 8'h00) bad++;
  endtask

  task automatic clearCounters();
    hdrA0 = 0; ackC0 = 0; weCnt = 0; bad = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0; CmdW = 1'b0; DataW = 8'h00; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nChecks++;
    if ({CmdR, DataR, reg_we, reg_waddr, reg_wdata, reg_raddr, err_ovf, err_proto} !==
        {1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0})
      $display("FAIL reset_state got CmdR=%b DataR=%h we=%b wa=%h wd=%h ra=%h ovf=%b proto=%b",
               CmdR, DataR, reg_we, reg_waddr, reg_wdata, reg_raddr, err_ovf, err_proto);
    else nPassed++;
    rst = 1'b1;
    repeat (2) step(1'b0, 8'h00);
  endtask

  task automatic test_write();
    clearCounters();
    step(1'b1, 8'h40); step(1'b0, 8'h10); step(1'b0, 8'h02);
    step(1'b0, 8'hAA);
    nChecks++;
    if ({reg_we, reg_waddr, reg_wdata} !== {1'b1, 8'h10, 8'hAA})
      $display("FAIL write_byte0 got we=%b a=%h d=%h want 1 10 AA", reg_we, reg_waddr, reg_wdata);
    else nPassed++;
    step(1'b0, 8'hBB);
    nChecks++;
    if ({reg_we, reg_waddr, reg_wdata} !== {1'b1, 8'h11, 8'hBB})
      $display("FAIL write_byte1 got we=%b a=%h d=%h want 1 11 BB", reg_we, reg_waddr, reg_wdata);
    else nPassed++;
    step(1'b0, 8'h00);
    nChecks++;
    if ({reg_we, CmdR, DataR} !== {1'b0, 1'b1, 8'h00})
      $display("FAIL write_pop_cycle got we=%b CmdR=%b DataR=%h want 0 1 00", reg_we, CmdR, DataR);
    else nPassed++;
    step(1'b0, 8'h00);
    nChecks++;
    if ({CmdR, DataR} !== {1'b1, 8'hC0})
      $display("FAIL write_ack got CmdR=%b DataR=%h want 1 C0", CmdR, DataR);
    else nPassed++;
    step(1'b0, 8'h00);
    nChecks++;
    if ({CmdR, DataR, weCnt} !== {1'b1, 8'h00, 32'd2})
      $display("FAIL write_after_ack got CmdR=%b DataR=%h weCnt=%0d want 1 00 2", CmdR, DataR, weCnt);
    else nPassed++;
  endtask

  task automatic test_write_len0();
    clearCounters();
    step(1'b1, 8'h40); step(1'b0, 8'h20); step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    nChecks++;
    if ({CmdR, DataR, weCnt} !== {1'b1, 8'hC0, 32'd0})
      $display("FAIL write_len0_ack got CmdR=%b DataR=%h weCnt=%0d want 1 C0 0", CmdR, DataR, weCnt);
    else nPassed++;
    step(1'b0, 8'h00);
  endtask

  task automatic test_read();
    step(1'b1, 8'h20); step(1'b0, 8'h10); step(1'b0, 8'h02);
    step(1'b0, 8'h00);
    nChecks++;
    if ({CmdR, DataR} !== {1'b1, 8'h00})
      $display("FAIL read_pop_cycle got CmdR=%b DataR=%h want 1 00", CmdR, DataR);
    else nPassed++;
    step(1'b0, 8'h00);
    nChecks++;
    if ({CmdR, DataR, reg_raddr} !== {1'b1, 8'hA0, 8'h10})
      $display("FAIL read_hdr got CmdR=%b DataR=%h ra=%h want 1 A0 10", CmdR, DataR, reg_raddr);
    else nPassed++;
    step(1'b0, 8'h00);
    nChecks++;
    if ({CmdR, DataR} !== {1'b0, 8'hAA})
      $display("FAIL read_data0 got CmdR=%b DataR=%h want 0 AA", CmdR, DataR);
    else nPassed++;
    step(1'b0, 8'h00);
    nChecks++;
    if ({CmdR, DataR} !== {1'b0, 8'hBB})
      $display("FAIL read_data1 got CmdR=%b DataR=%h want 0 BB", CmdR, DataR);
    else nPassed++;
    step(1'b0, 8'h00);
    nChecks++;
    if ({CmdR, DataR} !== {1'b1, 8'h00})
      $display("FAIL read_end_idle got CmdR=%b DataR=%h want 1 00", CmdR, DataR);
    else nPassed++;
  endtask

  task automatic test_read_wrap();
    step(1'b1, 8'h20); step(1'b0, 8'hFF); step(1'b0, 8'h02);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    nChecks++;
    if ({CmdR, DataR, reg_raddr} !== {1'b1, 8'hA0, 8'hFF})
      $display("FAIL wrap_hdr got CmdR=%b DataR=%h ra=%h want 1 A0 FF", CmdR, DataR, reg_raddr);
    else nPassed++;
    step(1'b0, 8'h00);
    nChecks++;
    if ({CmdR, DataR, reg_raddr} !== {1'b0, 8'hA5, 8'h00})
      $display("FAIL wrap_data0 got CmdR=%b DataR=%h ra=%h want 0 A5 00", CmdR, DataR, reg_raddr);
    else nPassed++;
    step(1'b0, 8'h00);
    nChecks++;
    if ({CmdR, DataR} !== {1'b0, 8'h5A})
      $display("FAIL wrap_data1 got CmdR=%b DataR=%h want 0 5A", CmdR, DataR);
    else nPassed++;
    step(1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    clearCounters();
    nChecks++;
    if (err_ovf !== 1'b0) $display("FAIL ovf_initial got %b want 0", err_ovf);
    else nPassed++;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'h20); step(1'b0, 8'h40); step(1'b0, 8'h20);
      if (i == 4) begin
        nChecks++;
        if (err_ovf !== 1'b0) $display("FAIL ovf_after_5th got %b want 0", err_ovf);
        else nPassed++;
      end
    end
    nChecks++;
    if (err_ovf !== 1'b1) $display("FAIL ovf_after_6th got %b want 1", err_ovf);
    else nPassed++;
    repeat (300) step(1'b0, 8'h00);
    nChecks++;
    if ({hdrA0, CmdR, DataR} !== {32'd5, 1'b1, 8'h00})
      $display("FAIL ovf_responses got hdrs=%0d CmdR=%b DataR=%h want 5 1 00", hdrA0, CmdR, DataR);
    else nPassed++;
    err_clr = 1'b1;
    step(1'b0, 8'h00);
    err_clr = 1'b0;
    nChecks++;
    if ({err_ovf, err_proto} !== 2'b00)
      $display("FAIL ovf_clear got ovf=%b proto=%b want 0 0", err_ovf, err_proto);
    else nPassed++;
  endtask

  task automatic test_abort();
    clearCounters();
    step(1'b1, 8'h40); step(1'b0, 8'h10);
    step(1'b1, 8'h20);
    nChecks++;
    if (err_proto !== 1'b1) $display("FAIL abort_proto got %b want 1", err_proto);
    else nPassed++;
    step(1'b0, 8'h30); step(1'b0, 8'h01);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    nChecks++;
    if ({CmdR, DataR} !== {1'b1, 8'hA0})
      $display("FAIL abort_read_hdr got CmdR=%b DataR=%h want 1 A0", CmdR, DataR);
    else nPassed++;
    step(1'b0, 8'h00);
    nChecks++;
    if ({CmdR, DataR} !== {1'b0, 8'h6A})
      $display("FAIL abort_read_data got CmdR=%b DataR=%h want 0 6A", CmdR, DataR);
    else nPassed++;
    repeat (4) step(1'b0, 8'h00);
    nChecks++;
    if ({ackC0, weCnt} !== {32'd0, 32'd0})
      $display("FAIL abort_no_write got acks=%0d we=%0d want 0 0", ackC0, weCnt);
    else nPassed++;
    err_clr = 1'b1;
    step(1'b0, 8'h00);
    err_clr = 1'b0;
    nChecks++;
    if (err_proto !== 1'b0) $display("FAIL proto_clear got %b want 0", err_proto);
    else nPassed++;
    step(1'b1, 8'hE0);
    nChecks++;
    if (err_proto !== 1'b1) $display("FAIL illegal_opcode got %b want 1", err_proto);
    else nPassed++;
    err_clr = 1'b1;
    step(1'b0, 8'h00);
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    step(1'b1, 8'h20); step(1'b0, 8'h00); step(1'b0, 8'h08);
    repeat (3) step(1'b0, 8'h00);
    nChecks++;
    if (CmdR !== 1'b0) $display("FAIL midread_in_data got CmdR=%b want 0", CmdR);
    else nPassed++;
    #2 rst = 1'b0;
    #1;
    nChecks++;
    if ({CmdR, DataR, reg_raddr} !== {1'b1, 8'h00, 8'h00})
      $display("FAIL async_reset got CmdR=%b DataR=%h ra=%h want 1 00 00", CmdR, DataR, reg_raddr);
    else nPassed++;
    @(posedge clk);
    #3 rst = 1'b1;
    clearCounters();
    repeat (20) step(1'b0, 8'h00);
    nChecks++;
    if (bad !== 0) $display("FAIL after_reset_quiet got %0d non-idle bytes want 0", bad);
    else nPassed++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_write_len0();
    test_read();
    test_read_wrap();
    test_back_to_back();
    test_abort();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
